score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper_if.sv | 27 ++
 rtl/score_keeper.sv | 201 ++++++++++++++++++++
 tb/tb_score_keeper.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/score_keeper_if.sv
// Event inputs and display outputs of the score keeper, bundled for the design port.
interface score_keeper_if;
  logic            startOfFrame;
  logic            addEvent;
  logic [3:0]      addValue;
  logic            subEvent;
  logic [3:0]      subValue;
  logic            clearScore;
  logic            goalLoad;
  logic [11:0]     goalValue;
  logic [5:0][3:0] numbersToShow;
  logic            SignToShow;
  logic            ShowSign;
  logic            goalReached;

  modport master (
    output startOfFrame, addEvent, addValue, subEvent, subValue,
           clearScore, goalLoad, goalValue,
    input  numbersToShow, SignToShow, ShowSign, goalReached
  );

  modport slave (
    input  startOfFrame, addEvent, addValue, subEvent, subValue,
           clearScore, goalLoad, goalValue,
    output numbersToShow, SignToShow, ShowSign, goalReached
  );
endinterface

// File: rtl/score_keeper.sv
// Three-digit BCD score/goal keeper with deferred subtraction, a frame-timed
// +/- sign indicator and a goal-reached pulse.
module score_keeper #(
  parameter logic [11:0] GOAL_DEFAULT = 12'h100,
  parameter int          SIGN_FRAMES  = 30
) (
  input  logic           clk,
  input  logic           reset,
  score_keeper_if.slave  bus
);

  localparam int CW = (SIGN_FRAMES < 1) ? 1 : $clog2(SIGN_FRAMES + 1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_SHOWING = 1'b1;

  logic [11:0]   score_q, score_d;
  logic [11:0]   goal_q, goal_d;
  logic          pend_q, pend_d;
  logic [3:0]    pend_val_q, pend_val_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:0]    state_q, state_d;
  logic          sign_q, sign_d;
  logic          show_q, show_d;
  logic          goal_reached_q, goal_reached_d;

  logic [11:0]   base_s;
  logic [3:0]    add_v_s, sub_v_s;
  logic          applied_s;

  function automatic logic [3:0] clamp9(input logic [3:0] v);
    if (v > 4'd9) begin
      return 4'd9;
    end else begin
      return v;
    end
  endfunction

  // Digit-wise BCD add of a single digit into the units; carry out saturates at 999.
  function automatic logic [11:0] bcd_add(input logic [11:0] a, input logic [3:0] v);
    logic [11:0] r;
    logic [4:0]  s;
    logic        c;
    r = 12'h000;
    c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, a[4*i +: 4]} + ((i == 0) ? {1'b0, v} : {4'd0, c});
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    return c ? 12'h999 : r;
  endfunction

  // Digit-wise BCD subtract; a borrow out of the hundreds saturates at 000.
  function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [3:0] v);
    logic [11:0] r;
    logic [4:0]  ad;
    logic [4:0]  sd;
    logic        b;
    r = 12'h000;
    b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ad = {1'b0, a[4*i +: 4]};
      sd = (i == 0) ? {1'b0, v} : {4'd0, b};
      if (ad < sd) begin
        r[4*i +: 4] = 4'(ad + 5'd10 - sd);
        b = 1'b1;
      end else begin
        r[4*i +: 4] = 4'(ad - sd);
        b = 1'b0;
      end
    end
    return b ? 12'h000 : r;
  endfunction

  // Next-state for score, goal, pending sub, sign FSM and goal pulse.
  always_comb begin
    score_d        = score_q;
    goal_d         = goal_q;
    pend_d         = pend_q;
    pend_val_d     = pend_val_q;
    cnt_d          = cnt_q;
    state_d        = state_q;
    sign_d         = sign_q;
    applied_s      = 1'b0;
    add_v_s        = clamp9(bus.addValue);
    sub_v_s        = clamp9(bus.subValue);
    base_s         = pend_q ? bcd_sub(score_q, pend_val_q) : score_q;

    if (bus.goalLoad) begin
      goal_d = {clamp9(bus.goalValue[11:8]), clamp9(bus.goalValue[7:4]),
                clamp9(bus.goalValue[3:0])};
    end else begin
      goal_d = goal_q;
    end

    if (bus.clearScore) begin
      score_d    = 12'h000;
      pend_d     = 1'b0;
      pend_val_d = 4'd0;
      cnt_d      = {CW{1'b0}};
      state_d    = ST_IDLE;
    end else begin
      // A pending sub always lands first; a new sub paired with an add takes the freed slot.
      if (bus.addEvent) begin
        score_d   = bcd_add(base_s, add_v_s);
        sign_d    = 1'b0;
        applied_s = 1'b1;
        if (bus.subEvent) begin
          pend_d     = 1'b1;
          pend_val_d = sub_v_s;
        end else begin
          pend_d     = 1'b0;
          pend_val_d = 4'd0;
        end
      end else if (bus.subEvent) begin
        score_d    = bcd_sub(base_s, sub_v_s);
        sign_d     = 1'b1;
        applied_s  = 1'b1;
        pend_d     = 1'b0;
        pend_val_d = 4'd0;
      end else if (pend_q) begin
        score_d    = base_s;
        sign_d     = 1'b1;
        applied_s  = 1'b1;
        pend_d     = 1'b0;
        pend_val_d = 4'd0;
      end else begin
        score_d = score_q;
      end

      if (applied_s) begin
        state_d = ST_SHOWING;
        cnt_d   = CW'(SIGN_FRAMES);
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_IDLE;
          end
          ST_SHOWING: begin
            if (bus.startOfFrame) begin
              if (cnt_q <= CW'(1)) begin
                cnt_d   = {CW{1'b0}};
                state_d = ST_IDLE;
              end else begin
                cnt_d = cnt_q - CW'(1);
              end
            end else if (cnt_q == {CW{1'b0}}) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_SHOWING;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = {CW{1'b0}};
          end
        endcase
      end
    end

    show_d         = (state_d == ST_SHOWING);
    goal_reached_d = (score_d >= goal_d) && !(score_q >= goal_q);
  end

  // State registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q        <= 12'h000;
      goal_q         <= GOAL_DEFAULT;
      pend_q         <= 1'b0;
      pend_val_q     <= 4'd0;
      cnt_q          <= {CW{1'b0}};
      state_q        <= ST_IDLE;
      sign_q         <= 1'b0;
      show_q         <= 1'b0;
      goal_reached_q <= 1'b0;
    end else begin
      score_q        <= score_d;
      goal_q         <= goal_d;
      pend_q         <= pend_d;
      pend_val_q     <= pend_val_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      sign_q         <= sign_d;
      show_q         <= show_d;
      goal_reached_q <= goal_reached_d;
    end
  end

  assign bus.numbersToShow = {score_q, goal_q};
  assign bus.SignToShow    = sign_q;
  assign bus.ShowSign      = show_q;
  assign bus.goalReached   = goal_reached_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with SIGN_FRAMES=3 and the default goal of 100.
module tb_score_keeper;
  logic clk;
  logic reset;
  int   checks;
  int   passed;
  int   pulses;

  score_keeper_if bus ();

  score_keeper #(.GOAL_DEFAULT(12'h100), .SIGN_FRAMES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [11:0] score_s;
  logic [11:0] goal_s;
  assign score_s = bus.numbersToShow[5:3];
  assign goal_s  = bus.numbersToShow[2:0];

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_add(input logic [3:0] v);
    bus.addEvent = 1'b1; bus.addValue = v;
    cyc();
    bus.addEvent = 1'b0; bus.addValue = 4'd0;
  endtask

  task automatic do_sub(input logic [3:0] v);
    bus.subEvent = 1'b1; bus.subValue = v;
    cyc();
    bus.subEvent = 1'b0; bus.subValue = 4'd0;
  endtask

  task automatic do_sof();
    bus.startOfFrame = 1'b1;
    cyc();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic set_score(input int v);
    int rem;
    rem = v;
    bus.clearScore = 1'b1;
    cyc();
    bus.clearScore = 1'b0;
    while (rem > 0) begin
      do_add((rem >= 9) ? 4'd9 : 4'(rem));
      rem = (rem >= 9) ? rem - 9 : 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.numbersToShow !== 24'h000100) $display("FAIL reset_numbers: got %h want %h", bus.numbersToShow, 24'h000100); else passed++;
    checks++; if (bus.ShowSign !== 1'b0) $display("FAIL reset_show: got %b want 0", bus.ShowSign); else passed++;
    checks++; if (bus.SignToShow !== 1'b0) $display("FAIL reset_sign: got %b want 0", bus.SignToShow); else passed++;
    checks++; if (bus.goalReached !== 1'b0) $display("FAIL reset_goal: got %b want 0", bus.goalReached); else passed++;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_carry();
    set_score(96);
    do_sub(4'd1);
    checks++; if (score_s !== 12'h095 || bus.SignToShow !== 1'b1) $display("FAIL carry_pre: got %h/%b want 095/1", score_s, bus.SignToShow); else passed++;
    do_add(4'd7);
    checks++; if (score_s !== 12'h102) $display("FAIL carry_score: got %h want 102", score_s); else passed++;
    checks++; if (bus.ShowSign !== 1'b1 || bus.SignToShow !== 1'b0) $display("FAIL carry_sign: got show=%b sign=%b want 1/0", bus.ShowSign, bus.SignToShow); else passed++;
  endtask

  task automatic test_clamp();
    set_score(10);
    do_add(4'hF);
    checks++; if (score_s !== 12'h019) $display("FAIL clamp_add: got %h want 019", score_s); else passed++;
    do_sub(4'hC);
    checks++; if (score_s !== 12'h010) $display("FAIL clamp_sub: got %h want 010", score_s); else passed++;
  endtask

  task automatic test_saturation();
    set_score(995);
    checks++; if (score_s !== 12'h995) $display("FAIL sat_pre: got %h want 995", score_s); else passed++;
    do_add(4'd9);
    checks++; if (score_s !== 12'h999) $display("FAIL sat_top: got %h want 999", score_s); else passed++;
    bus.clearScore = 1'b1; cyc(); bus.clearScore = 1'b0;
    checks++; if (score_s !== 12'h000 || bus.ShowSign !== 1'b0) $display("FAIL sat_clear: got %h/%b want 000/0", score_s, bus.ShowSign); else passed++;
    do_sub(4'd3);
    checks++; if (score_s !== 12'h000 || bus.SignToShow !== 1'b1 || bus.ShowSign !== 1'b1) $display("FAIL sat_bottom: got %h/%b/%b want 000/1/1", score_s, bus.SignToShow, bus.ShowSign); else passed++;
  endtask

  task automatic test_simultaneous();
    set_score(50);
    bus.addEvent = 1'b1; bus.addValue = 4'd4; bus.subEvent = 1'b1; bus.subValue = 4'd6;
    cyc();
    bus.addEvent = 1'b0; bus.subEvent = 1'b0;
    checks++; if (score_s !== 12'h054 || bus.SignToShow !== 1'b0) $display("FAIL simul_c1: got %h/%b want 054/0", score_s, bus.SignToShow); else passed++;
    cyc();
    checks++; if (score_s !== 12'h048 || bus.SignToShow !== 1'b1) $display("FAIL simul_c2: got %h/%b want 048/1", score_s, bus.SignToShow); else passed++;
  endtask

  task automatic test_back_to_back();
    set_score(50);
    bus.addEvent = 1'b1; bus.addValue = 4'd4; bus.subEvent = 1'b1; bus.subValue = 4'd6;
    cyc();
    bus.addValue = 4'd1; bus.subValue = 4'd2;
    cyc();
    bus.addEvent = 1'b0; bus.subEvent = 1'b0;
    checks++; if (score_s !== 12'h049 || bus.SignToShow !== 1'b0) $display("FAIL b2b_c2: got %h/%b want 049/0", score_s, bus.SignToShow); else passed++;
    cyc();
    checks++; if (score_s !== 12'h047 || bus.SignToShow !== 1'b1) $display("FAIL b2b_c3: got %h/%b want 047/1", score_s, bus.SignToShow); else passed++;
    cyc();
    checks++; if (score_s !== 12'h047) $display("FAIL b2b_idle: got %h want 047", score_s); else passed++;
  endtask

  task automatic test_clear_priority();
    set_score(50);
    bus.addEvent = 1'b1; bus.addValue = 4'd2; bus.subEvent = 1'b1; bus.subValue = 4'd3;
    cyc();
    bus.subEvent = 1'b0; bus.addValue = 4'd5; bus.clearScore = 1'b1;
    cyc();
    bus.addEvent = 1'b0; bus.clearScore = 1'b0;
    checks++; if (score_s !== 12'h000 || bus.ShowSign !== 1'b0) $display("FAIL clr_prio: got %h/%b want 000/0", score_s, bus.ShowSign); else passed++;
    cyc();
    checks++; if (score_s !== 12'h000 || bus.ShowSign !== 1'b0) $display("FAIL clr_pend: got %h/%b want 000/0", score_s, bus.ShowSign); else passed++;
  endtask

  task automatic test_sign_timer();
    do_add(4'd1);
    do_sof(); cyc(); do_sof(); cyc();
    checks++; if (bus.ShowSign !== 1'b1) $display("FAIL timer_two: got %b want 1", bus.ShowSign); else passed++;
    do_sof();
    checks++; if (bus.ShowSign !== 1'b0) $display("FAIL timer_expire: got %b want 0", bus.ShowSign); else passed++;
    do_add(4'd1);
    do_sof(); do_sof();
    do_add(4'd1);
    do_sof(); do_sof();
    checks++; if (bus.ShowSign !== 1'b1) $display("FAIL timer_restart: got %b want 1", bus.ShowSign); else passed++;
    do_sof();
    checks++; if (bus.ShowSign !== 1'b0) $display("FAIL timer_restart_end: got %b want 0", bus.ShowSign); else passed++;
    bus.startOfFrame = 1'b1;
    do_add(4'd1);
    bus.startOfFrame = 1'b0;
    do_sof(); do_sof();
    checks++; if (bus.ShowSign !== 1'b1) $display("FAIL timer_coincident: got %b want 1", bus.ShowSign); else passed++;
    do_sof();
    checks++; if (bus.ShowSign !== 1'b0) $display("FAIL timer_coincident_end: got %b want 0", bus.ShowSign); else passed++;
  endtask

  task automatic test_goal();
    set_score(98);
    do_add(4'd2);
    pulses = int'(bus.goalReached);
    repeat (3) begin cyc(); pulses += int'(bus.goalReached); end
    checks++; if (pulses !== 1) $display("FAIL goal_cross: got %0d pulses want 1", pulses); else passed++;
    do_add(4'd1);
    pulses = int'(bus.goalReached);
    repeat (3) begin cyc(); pulses += int'(bus.goalReached); end
    checks++; if (pulses !== 0 || score_s !== 12'h101) $display("FAIL goal_above: got %0d pulses score %h want 0 / 101", pulses, score_s); else passed++;
    bus.goalLoad = 1'b1; bus.goalValue = 12'h050; cyc(); bus.goalLoad = 1'b0;
    pulses = int'(bus.goalReached);
    repeat (3) begin cyc(); pulses += int'(bus.goalReached); end
    checks++; if (pulses !== 0 || goal_s !== 12'h050 || score_s !== 12'h101) $display("FAIL goal_load_low: got %0d/%h/%h want 0/050/101", pulses, goal_s, score_s); else passed++;
    bus.goalLoad = 1'b1; bus.goalValue = 12'hFA3; cyc(); bus.goalLoad = 1'b0;
    checks++; if (goal_s !== 12'h993) $display("FAIL goal_clamp: got %h want 993", goal_s); else passed++;
    bus.goalLoad = 1'b1; bus.goalValue = 12'h100; cyc(); bus.goalLoad = 1'b0;
    pulses = int'(bus.goalReached);
    repeat (3) begin cyc(); pulses += int'(bus.goalReached); end
    checks++; if (pulses !== 1) $display("FAIL goal_lowered: got %0d pulses want 1", pulses); else passed++;
  endtask

  task automatic test_reset_mid();
    set_score(50);
    bus.addEvent = 1'b1; bus.addValue = 4'd4; bus.subEvent = 1'b1; bus.subValue = 4'd6;
    cyc();
    bus.addEvent = 1'b0; bus.subEvent = 1'b0;
    reset = 1'b1;
    #2;
    checks++; if (bus.numbersToShow !== 24'h000100) $display("FAIL rstmid_numbers: got %h want %h", bus.numbersToShow, 24'h000100); else passed++;
    checks++; if (bus.ShowSign !== 1'b0 || bus.SignToShow !== 1'b0 || bus.goalReached !== 1'b0) $display("FAIL rstmid_flags: got %b%b%b want 000", bus.ShowSign, bus.SignToShow, bus.goalReached); else passed++;
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc();
    checks++; if (score_s !== 12'h000 || bus.ShowSign !== 1'b0) $display("FAIL rstmid_residue: got %h/%b want 000/0", score_s, bus.ShowSign); else passed++;
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    checks = 0;
    passed = 0;
    bus.startOfFrame = 1'b0;
    bus.addEvent = 1'b0;
    bus.addValue = 4'd0;
    bus.subEvent = 1'b0;
    bus.subValue = 4'd0;
    bus.clearScore = 1'b0;
    bus.goalLoad = 1'b0;
    bus.goalValue = 12'h000;
    test_reset();
    test_carry();
    test_clamp();
    test_saturation();
    test_simultaneous();
    test_back_to_back();
    test_clear_priority();
    test_sign_timer();
    test_goal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
